// File: rtl/io_uart_responder_pkg.sv
// Shared types and constants for the memory-mapped UART responder.
// Op codes, FSM encodings and the fixed illegal-op response word.
`timescale 1ns/1ps
package io_uart_responder_pkg;

  localparam int WORD_DEF = 32;
  localparam logic [31:0] ILLEGAL_RESP = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_TX   = 2'b00,
    OP_RX   = 2'b01,
    OP_STAT = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TX,
    ST_RX_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/io_uart_responder_uart_rx_core.sv
// 8N1 UART receiver: synchronizer, bit timer, shifter, framing check.
// Emits the received byte with a one-cycle byte_valid strobe.
`timescale 1ns/1ps
module uart_rx_core
  import io_uart_responder_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid
);

  localparam int CW = $clog2(CLK_DIV);

  logic            s1;
  logic            s2;
  logic            s3;
  rx_state_e       st;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      s3         <= 1'b1;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
    end else begin
      s1         <= rxd;
      s2         <= s1;
      s3         <= s2;
      byte_valid <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          if (s3 && !s2) begin
            st  <= RX_START;
            cnt <= '0;
          end
        end
        // half-bit wait puts every later sample mid-bit
        RX_START: begin
          if (cnt == CW'(CLK_DIV/2 - 1)) begin
            cnt     <= '0;
            bit_cnt <= '0;
            st      <= s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt     <= '0;
            shreg   <= {s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7)
              st <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CW'(CLK_DIV - 1)) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (s2) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_responder.sv
// CPU IO responder: UART TX, RX read and status ops over start/clear.
// Build with IO_LOOPBACK_EN to feed the receiver from uart_txd.
`timescale 1ns/1ps
module io_uart_responder
  import io_uart_responder_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int WORD    = WORD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            clear,
  input  logic [WORD-1:0] t_data,
  output logic [WORD-1:0] data_to_t,
  output logic            ready,
  output logic            busy,
  output logic            uart_txd,
  input  logic            uart_rxd
);

  localparam int CW = $clog2(CLK_DIV);

  state_e        state;
  op_e           op;
  logic [CW-1:0] cyc_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    tx_shift;
  logic [7:0]    tx_byte;
  logic [7:0]    rx_buf;
  logic          rx_full;
  logic          overrun;
  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          rx_in;
  logic          consume;
  logic          stat_rd;
  logic          unused_tdata;

  assign op           = op_e'(t_data[WORD-1 -: 2]);
  assign unused_tdata = ^t_data[WORD-3:8];

`ifdef IO_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = uart_rxd;
  assign rx_in      = uart_txd;
`else
  assign rx_in      = uart_rxd;
`endif

  assign consume = (state == ST_RX_WAIT) && rx_full && !clear;
  assign stat_rd = (state == ST_IDLE) && start && (op == OP_STAT);

  uart_rx_core #(
    .CLK_DIV(CLK_DIV)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rx_in),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid)
  );

  // a same-cycle consume takes the old byte, so no overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf  <= '0;
      rx_full <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (byte_valid) begin
        rx_buf  <= rx_byte;
        rx_full <= 1'b1;
      end else if (consume) begin
        rx_full <= 1'b0;
      end
      if (byte_valid && rx_full && !consume)
        overrun <= 1'b1;
      else if (stat_rd)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      data_to_t <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      uart_txd  <= 1'b1;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '1;
      tx_byte   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            unique case (op)
              OP_TX: begin
                tx_byte  <= t_data[7:0];
                tx_shift <= {1'b1, t_data[7:0]};
                uart_txd <= 1'b0;
                cyc_cnt  <= '0;
                bit_cnt  <= '0;
                busy     <= 1'b1;
                state    <= ST_TX;
              end
              OP_RX: begin
                busy  <= 1'b1;
                state <= ST_RX_WAIT;
              end
              OP_STAT: begin
                data_to_t <= WORD'({overrun, rx_full});
                ready     <= 1'b1;
                state     <= ST_DONE;
              end
              OP_ILL: begin
                data_to_t <= WORD'(ILLEGAL_RESP);
                ready     <= 1'b1;
                state     <= ST_DONE;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_TX: begin
          if (cyc_cnt == CW'(CLK_DIV - 1)) begin
            cyc_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              data_to_t <= WORD'(tx_byte);
              ready     <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_DONE;
            end else begin
              uart_txd <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        ST_RX_WAIT: begin
          if (clear) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (rx_full) begin
            data_to_t <= WORD'(rx_buf);
            busy      <= 1'b0;
            ready     <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (clear) begin
            ready <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
